// File: rtl/lcb_tx_sequencer.sv
// -----------------------------------------------------------------------------
// lcb_tx_sequencer
//
// Frame-level controller for the LCB answer path. A rising edge on rq_i turns
// the RS485 transceiver around to transmit, holds the line for a pre-guard
// period, walks the answer ROM from address 0 to FRAME_LEN-1 handing every byte
// to the byte-level UART transmitter, waits a post-guard period after the last
// byte and then releases the bus back to receive.
//
// Parameters
//   ADDR_W      answer ROM address width
//   FRAME_LEN   bytes per answer frame (1 .. 2**ADDR_W)
//   PRE_GUARD   clocks in the pre-guard state before the first byte (>= 1)
//   POST_GUARD  clocks after the last byte completes before dir_tx_o drops (>= 1)
//
// Ports
//   clk_i       transmit clock, all logic on the rising edge
//   rst_i       synchronous active-high reset
//   rq_i        answer request; one frame per rising edge
//   rom_addr_o  answer ROM address
//   rom_data_i  registered ROM data, valid one clock after rom_addr_o changes
//   tx_ready_i  UART idle; falls the clock after tx_start_o, rises after stop bit
//   tx_start_o  one-clock pulse, UART loads tx_data_o
//   tx_data_o   byte to send, stable from one tx_start_o until the next
//   dir_tx_o    RS485 driver enable
//   dir_rx_o    RS485 receiver enable, active-low, always equal to dir_tx_o
//   busy_o      high in every state except idle
//   overrun_o   one-clock pulse: a request edge arrived while busy
// -----------------------------------------------------------------------------
module lcb_tx_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int FRAME_LEN  = 20,
    parameter int PRE_GUARD  = 8,
    parameter int POST_GUARD = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rq_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    input  logic              tx_ready_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    output logic              dir_tx_o,
    output logic              dir_rx_o,
    output logic              busy_o,
    output logic              overrun_o
);

    // One counter serves both guard periods, so it is sized for the longer one.
    localparam int GUARD_MAX = (PRE_GUARD > POST_GUARD) ? PRE_GUARD : POST_GUARD;
    localparam int CNT_W     = $clog2(GUARD_MAX + 1);

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_GUARD - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_GUARD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_LEN - 1);

    // Elaboration-time parameter sanity checks.
    if (FRAME_LEN < 1 || FRAME_LEN > (2 ** ADDR_W)) begin : g_bad_frame_len
        $error("lcb_tx_sequencer: FRAME_LEN must be in 1 .. 2**ADDR_W");
    end
    if (PRE_GUARD < 1) begin : g_bad_pre_guard
        $error("lcb_tx_sequencer: PRE_GUARD must be at least 1");
    end
    if (POST_GUARD < 1) begin : g_bad_post_guard
        $error("lcb_tx_sequencer: POST_GUARD must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,   // bus released, waiting for a request edge
        S_PRE,    // driver enabled, pre-guard running
        S_FETCH,  // ROM address settling into registered ROM data
        S_LOAD,   // waiting for the UART to accept the byte
        S_SEND,   // byte in flight, waiting for the UART to finish it
        S_POST    // last byte done, post-guard running
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                rq_q;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                dir_tx_q,   dir_tx_d;
    logic                overrun_q,  overrun_d;

    logic                rq_edge;

    // A level held high produces a single edge, hence a single frame.
    assign rq_edge = rq_i & ~rq_q;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of the
    // order the statements are written in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rq_q       <= 1'b0;
            rom_addr_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            dir_tx_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rq_q       <= rq_i;
            rom_addr_q <= rom_addr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            dir_tx_q   <= dir_tx_d;
            overrun_q  <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that skipped an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        dir_tx_d   = dir_tx_q;
        // Requests are neither queued nor restart a frame; they only flag.
        // This includes the clock on which POST hands back to IDLE.
        overrun_d  = rq_edge && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                dir_tx_d = 1'b0;
                if (rq_edge) begin
                    rom_addr_d = '0;
                    cnt_d      = '0;
                    dir_tx_d   = 1'b1;
                    state_d    = S_PRE;
                end
            end

            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                if (tx_ready_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rom_data_i;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                // tx_start_q is high only on the first SEND clock, which is the
                // clock where tx_ready_i still shows the pre-start idle level.
                if (!tx_start_q && tx_ready_i) begin
                    if (rom_addr_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = S_POST;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            S_POST: begin
                if (cnt_q == POST_LAST) begin
                    cnt_d      = '0;
                    dir_tx_d   = 1'b0;
                    rom_addr_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                // Unreachable encodings fall back to a released bus.
                cnt_d      = '0;
                dir_tx_d   = 1'b0;
                rom_addr_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_addr_o = rom_addr_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign dir_tx_o   = dir_tx_q;
    // Receiver enable is active-low, so tying it to the driver enable keeps
    // the receiver off exactly while the node drives the bus.
    assign dir_rx_o   = dir_tx_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_lcb_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcb_tx_sequencer
//
// Directed bench for lcb_tx_sequencer. Two instances share the clock and reset:
// u_dut0 with the default frame parameters and u_dut1 with FRAME_LEN=1 and
// one-clock guards. Each has a registered ROM model and a UART model that holds
// tx_ready low for UART_CLKS clocks per accepted byte. A monitor collects
// start pulses, transmitted bytes and bus-direction timestamps on the falling
// edge; the directed sequence samples shortly after the falling edge.
// -----------------------------------------------------------------------------
module tb_lcb_tx_sequencer;

    localparam int UART_CLKS = 10;
    localparam int PRE0  = 8;
    localparam int POST0 = 16;
    localparam int LEN0  = 20;
    localparam int PRE1  = 1;
    localparam int POST1 = 1;

    logic       clk;
    logic       rst;
    logic       rq        [2];
    logic [4:0] rom_addr  [2];
    logic [7:0] rom_data  [2];
    logic       tx_ready  [2];
    logic       tx_start  [2];
    logic [7:0] tx_data   [2];
    logic       dir_tx    [2];
    logic       dir_rx    [2];
    logic       busy      [2];
    logic       overrun   [2];

    logic       hold_low;
    logic       uart_idle [2];
    int         uart_cnt  [2];
    int         ready_rise_cyc [2];
    int         cyc;

    // Monitor results
    int         start_cnt      [2];
    int         wide_start     [2];
    logic       start_prev     [2];
    int         dir_rise_cyc   [2];
    int         dir_fall_cyc   [2];
    int         dir_rise_cnt   [2];
    int         dir_high_cnt   [2];
    logic       dir_prev       [2];
    int         overrun_cnt    [2];
    int         max_addr       [2];
    int         dir_rx_bad;
    logic [7:0] byte_q0 [$];
    int         start_cyc_q0 [$];
    logic [7:0] byte_q1 [$];

    int         vectors;
    int         miscompares;

    lcb_tx_sequencer #(
        .ADDR_W(5), .FRAME_LEN(LEN0), .PRE_GUARD(PRE0), .POST_GUARD(POST0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .rq_i(rq[0]),
        .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]),
        .tx_ready_i(tx_ready[0]), .tx_start_o(tx_start[0]), .tx_data_o(tx_data[0]),
        .dir_tx_o(dir_tx[0]), .dir_rx_o(dir_rx[0]), .busy_o(busy[0]),
        .overrun_o(overrun[0])
    );

    lcb_tx_sequencer #(
        .ADDR_W(5), .FRAME_LEN(1), .PRE_GUARD(PRE1), .POST_GUARD(POST1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .rq_i(rq[1]),
        .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]),
        .tx_ready_i(tx_ready[1]), .tx_start_o(tx_start[1]), .tx_data_o(tx_data[1]),
        .dir_tx_o(dir_tx[1]), .dir_rx_o(dir_rx[1]), .busy_o(busy[1]),
        .overrun_o(overrun[1])
    );

    assign tx_ready[0] = uart_idle[0] & ~hold_low;
    assign tx_ready[1] = uart_idle[1];

    function automatic logic [7:0] rom_val(input int i);
        return 8'((i * 37) ^ 8'h5A);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    // Registered answer ROM
    initial begin
        rom_data[0] = '0;
        rom_data[1] = '0;
        forever begin
            @(posedge clk);
            for (int ch = 0; ch < 2; ch++) rom_data[ch] <= rom_val(int'(rom_addr[ch]));
        end
    end

    // UART model: busy for UART_CLKS falling edges after accepting a byte
    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            uart_idle[ch] = 1'b1;
            uart_cnt[ch] = 0;
            ready_rise_cyc[ch] = 0;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (!uart_idle[ch]) begin
                    uart_cnt[ch] = uart_cnt[ch] - 1;
                    if (uart_cnt[ch] == 0) begin
                        uart_idle[ch] = 1'b1;
                        ready_rise_cyc[ch] = cyc;
                    end
                end else if (tx_start[ch] === 1'b1) begin
                    uart_idle[ch] = 1'b0;
                    uart_cnt[ch] = UART_CLKS;
                end
            end
        end
    end

    // Monitor
    initial begin
        dir_rx_bad = 0;
        for (int ch = 0; ch < 2; ch++) begin
            start_cnt[ch] = 0;    wide_start[ch] = 0;   start_prev[ch] = 1'b0;
            dir_rise_cyc[ch] = 0; dir_fall_cyc[ch] = 0; dir_rise_cnt[ch] = 0;
            dir_high_cnt[ch] = 0; dir_prev[ch] = 1'b0;  overrun_cnt[ch] = 0;
            max_addr[ch] = 0;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (tx_start[ch] === 1'b1) begin
                    start_cnt[ch]++;
                    if (start_prev[ch]) wide_start[ch]++;
                    if (ch == 0) begin
                        byte_q0.push_back(tx_data[0]);
                        start_cyc_q0.push_back(cyc);
                    end else begin
                        byte_q1.push_back(tx_data[1]);
                    end
                end
                start_prev[ch] = (tx_start[ch] === 1'b1);
                if (dir_tx[ch] === 1'b1 && !dir_prev[ch]) begin
                    dir_rise_cyc[ch] = cyc;
                    dir_rise_cnt[ch]++;
                end
                if (dir_tx[ch] !== 1'b1 && dir_prev[ch]) dir_fall_cyc[ch] = cyc;
                if (dir_tx[ch] === 1'b1) dir_high_cnt[ch]++;
                dir_prev[ch] = (dir_tx[ch] === 1'b1);
                if (overrun[ch] === 1'b1) overrun_cnt[ch]++;
                if (int'(rom_addr[ch]) > max_addr[ch]) max_addr[ch] = int'(rom_addr[ch]);
                if (dir_rx[ch] !== dir_tx[ch]) dir_rx_bad++;
            end
        end
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Pulse rq for one clock; c is the cycle at which rq was raised.
    task automatic pulse_rq(input int ch, output int c);
        rq[ch] = 1'b1;
        c = cyc;
        tick();
        rq[ch] = 1'b0;
    endtask

    task automatic wait_dir_low(input int ch, input string tag);
        int n;
        n = 0;
        while (dir_tx[ch] !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(dir_tx[ch] === 1'b0), 1);
    endtask

    task automatic wait_starts(input int ch, input int target, input string tag);
        int n;
        n = 0;
        while (start_cnt[ch] < target && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(start_cnt[ch] >= target), 1);
    endtask

    // Number of bytes in byte_q0 from index qb that differ from ROM[0..LEN0-1]
    function automatic int frame_errors(input int qb);
        int bad;
        bad = 0;
        if (byte_q0.size() < qb + LEN0) return LEN0;
        for (int i = 0; i < LEN0; i++) if (byte_q0[qb + i] !== rom_val(i)) bad++;
        return bad;
    endfunction

    initial begin
        int c;
        int base;
        int qb;
        int ov;
        int rises;
        int r;
        int dir_low;
        int h1;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        hold_low = 1'b0;
        repeat (3) tick();

        // ---- Reset values
        check("rst_outputs", {27'd0, dir_tx[0], dir_rx[0], busy[0], tx_start[0], overrun[0]}, 0);
        check("rst_rom_addr", 32'(rom_addr[0]), 0);
        check("rst_tx_data", 32'(tx_data[0]), 0);
        rst = 1'b0;
        repeat (2) tick();
        check("idle_dir_tx", 32'(dir_tx[0]), 0);

        // ---- 1: single frame, timing and content
        base = start_cnt[0];
        qb = byte_q0.size();
        pulse_rq(0, c);
        // rq sampled on the edge ending cycle c; driver on right after it
        check("t1_dir_rise_lat", dir_rise_cyc[0] - c, 1);
        check("t1_busy", 32'(busy[0]), 1);
        wait_dir_low(0, "t1_frame_end");
        check("t1_starts", start_cnt[0] - base, LEN0);
        check("t1_first_start_lat", start_cyc_q0[qb] - (c + 1), PRE0 + 2);
        check("t1_bytes", frame_errors(qb), 0);
        check("t1_post_lat", dir_fall_cyc[0] - ready_rise_cyc[0], POST0 + 1);
        check("t1_max_addr", max_addr[0], LEN0 - 1);
        check("t1_start_width", wide_start[0], 0);
        check("t1_addr_home", 32'(rom_addr[0]), 0);
        check("t1_busy_end", 32'(busy[0]), 0);

        // ---- 2: rq held high for 500 clocks starts exactly one frame
        base = start_cnt[0];
        ov = overrun_cnt[0];
        rises = dir_rise_cnt[0];
        rq[0] = 1'b1;
        repeat (500) tick();
        check("t2_starts", start_cnt[0] - base, LEN0);
        check("t2_frames", dir_rise_cnt[0] - rises, 1);
        check("t2_overrun", overrun_cnt[0] - ov, 0);
        check("t2_dir_tx_end", 32'(dir_tx[0]), 0);
        rq[0] = 1'b0;
        repeat (5) tick();

        // ---- 3: second request during byte 7
        base = start_cnt[0];
        qb = byte_q0.size();
        ov = overrun_cnt[0];
        rises = dir_rise_cnt[0];
        pulse_rq(0, c);
        wait_starts(0, base + 8, "t3_reach_byte7");
        pulse_rq(0, c);
        check("t3_overrun_pulse", 32'(overrun[0]), 1);
        tick();
        check("t3_overrun_clear", 32'(overrun[0]), 0);
        wait_dir_low(0, "t3_frame_end");
        check("t3_starts", start_cnt[0] - base, LEN0);
        check("t3_bytes", frame_errors(qb), 0);
        check("t3_overrun_cnt", overrun_cnt[0] - ov, 1);
        repeat (50) tick();
        check("t3_no_second_frame", dir_rise_cnt[0] - rises, 1);

        // ---- 4: tx_ready held low for 100 clocks before byte 3
        base = start_cnt[0];
        qb = byte_q0.size();
        pulse_rq(0, c);
        r = 0;
        while (int'(rom_addr[0]) != 3 && r < 3000) begin
            tick();
            r++;
        end
        check("t4_reach_addr3", 32'(rom_addr[0]), 3);
        hold_low = 1'b1;
        dir_low = 0;
        repeat (100) begin
            tick();
            if (dir_tx[0] !== 1'b1) dir_low++;
        end
        check("t4_withheld", start_cnt[0] - base, 3);
        check("t4_dir_held", dir_low, 0);
        hold_low = 1'b0;
        r = cyc;
        tick();
        check("t4_resume_start", 32'(tx_start[0]), 1);
        check("t4_resume_lat", start_cyc_q0[qb + 3] - r, 1);
        wait_dir_low(0, "t4_frame_end");
        check("t4_bytes", frame_errors(qb), 0);

        // ---- 5: reset during byte 12, then a fresh frame from address 0
        base = start_cnt[0];
        pulse_rq(0, c);
        wait_starts(0, base + 13, "t5_reach_byte12");
        rst = 1'b1;
        tick();
        check("t5_rst_state", {29'd0, dir_tx[0], busy[0], tx_start[0]}, 0);
        check("t5_rst_addr", 32'(rom_addr[0]), 0);
        rst = 1'b0;
        tick();
        base = start_cnt[0];
        qb = byte_q0.size();
        pulse_rq(0, c);
        check("t5_restart_dir", 32'(dir_tx[0]), 1);
        wait_dir_low(0, "t5_frame_end");
        check("t5_starts", start_cnt[0] - base, LEN0);
        check("t5_bytes", frame_errors(qb), 0);

        // ---- 6: FRAME_LEN=1, one-clock guards
        base = start_cnt[1];
        h1 = dir_high_cnt[1];
        pulse_rq(1, c);
        wait_dir_low(1, "t6_frame_end");
        check("t6_starts", start_cnt[1] - base, 1);
        check("t6_byte", 32'(byte_q1[byte_q1.size() - 1]), 32'(rom_val(0)));
        // 4 clocks of sequencing plus the byte: UART_CLKS busy + 1 sampling edge
        check("t6_dir_high", dir_high_cnt[1] - h1, 4 + UART_CLKS + 1);
        check("t6_post_lat", dir_fall_cyc[1] - ready_rise_cyc[1], POST1 + 1);
        check("t6_max_addr", max_addr[1], 0);

        // Request edge on the clock where POST returns to IDLE
        base = start_cnt[1];
        ov = overrun_cnt[1];
        pulse_rq(1, c);
        wait_starts(1, base + 1, "t6b_start");
        r = 0;
        while (tx_ready[1] !== 1'b1 && r < 100) begin
            tick();
            r++;
        end
        tick();
        pulse_rq(1, c);
        check("t6b_overrun", 32'(overrun[1]), 1);
        check("t6b_idle", {30'd0, dir_tx[1], busy[1]}, 0);
        repeat (20) tick();
        check("t6b_no_restart", start_cnt[1] - base, 1);
        check("t6b_overrun_cnt", overrun_cnt[1] - ov, 1);

        check("dir_rx_tracks_dir_tx", dir_rx_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
